// File: rtl/dram_responder.sv
// DRAM command-protocol responder: tracks per-bank state and timing, rejects illegal
// commands with a coded violation, and replays read/write data-beat timing.
module dram_responder #(
    parameter int BG_WIDTH     = 2,
    parameter int BANK_WIDTH   = 2,
    parameter int ROW_WIDTH    = 15,
    parameter int COLUMN_WIDTH = 10,
    parameter int T_RCD        = 24,
    parameter int T_RP         = 24,
    parameter int T_CAS        = 24,
    parameter int T_BURST      = 4,
    parameter int T_CCD_L      = 8,
    parameter int T_CCD_S      = 4,
    parameter int T_RRD_L      = 6,
    parameter int T_RRD_S      = 4,
    parameter int T_RFC        = 350
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cmd_valid,
    input  logic [2:0]                            cmd_op,
    input  logic [BG_WIDTH-1:0]                   cmd_bg,
    input  logic [BANK_WIDTH-1:0]                 cmd_bank,
    input  logic [ROW_WIDTH-1:0]                  cmd_row,
    input  logic [COLUMN_WIDTH-1:0]               cmd_col,
    output logic                                  rd_valid,
    output logic [BG_WIDTH-1:0]                   rd_bg,
    output logic [BANK_WIDTH-1:0]                 rd_bank,
    output logic [COLUMN_WIDTH-1:0]               rd_col,
    output logic [1:0]                            rd_beat,
    output logic                                  wr_req,
    output logic [1:0]                            wr_beat,
    output logic [2**(BG_WIDTH+BANK_WIDTH)-1:0]   bank_open,
    output logic                                  refreshing,
    output logic                                  viol,
    output logic [2:0]                            viol_code,
    output logic [15:0]                           viol_count
);
    localparam int BIDX  = BG_WIDTH + BANK_WIDTH;
    localparam int NB    = 2**BIDX;
    localparam int NG    = 2**BG_WIDTH;
    // Stage k holds a command accepted k+1 cycles ago; together with the accepting
    // cycle this spans T_CAS+T_BURST cycles of tag history.
    localparam int DEPTH = T_CAS + T_BURST - 1;

    // Counters load T-1 so that a value of 0 is first seen exactly T cycles after acceptance.
    localparam logic [9:0]  RCD_LOAD   = 10'(T_RCD   > 0 ? T_RCD   - 1 : 0);
    localparam logic [9:0]  RP_LOAD    = 10'(T_RP    > 0 ? T_RP    - 1 : 0);
    localparam logic [9:0]  CCDL_LOAD  = 10'(T_CCD_L > 0 ? T_CCD_L - 1 : 0);
    localparam logic [9:0]  CCDS_LOAD  = 10'(T_CCD_S > 0 ? T_CCD_S - 1 : 0);
    localparam logic [9:0]  RRDL_LOAD  = 10'(T_RRD_L > 0 ? T_RRD_L - 1 : 0);
    localparam logic [9:0]  RRDS_LOAD  = 10'(T_RRD_S > 0 ? T_RRD_S - 1 : 0);
    localparam logic [15:0] RFC_LOAD   = 16'(T_RFC   > 0 ? T_RFC   - 1 : 0);

    localparam logic [2:0] OP_RD = 3'd0, OP_WR = 3'd1, OP_ACT = 3'd2, OP_PRE = 3'd3, OP_REF = 3'd4;

    typedef enum logic { G_RUN, G_REFRESH } gstate_t;
    typedef enum logic { B_CLOSED, B_OPEN } bstate_t;

    typedef struct packed {
        logic                    valid;
        logic                    is_rd;
        logic [BG_WIDTH-1:0]     bg;
        logic [BANK_WIDTH-1:0]   bank;
        logic [COLUMN_WIDTH-1:0] col;
    } entry_t;

    gstate_t                g_state, g_next;
    bstate_t                bank_state [NB];
    bstate_t                bank_next  [NB];
    logic [9:0]             ready_cnt  [NB];
    logic [ROW_WIDTH-1:0]   open_row   [NB];
    logic [9:0]             rrd_l_cnt  [NG];
    logic [9:0]             rrd_s_cnt  [NG];
    logic [9:0]             ccd_l_cnt  [NG];
    logic [9:0]             ccd_s_cnt  [NG];
    logic [15:0]            rfc_cnt;
    entry_t                 pipe       [DEPTH];
    entry_t                 new_entry;

    logic [BIDX-1:0] idx;
    logic            any_open, any_busy, rrd_block, ccd_block;
    logic [2:0]      reject_code;
    logic            accept, reject, is_rdwr;

    function automatic logic [9:0] dec10(input logic [9:0] v);
        return (v == 10'd0) ? v : v - 10'd1;
    endfunction

    assign idx     = {cmd_bg, cmd_bank};
    assign is_rdwr = (cmd_op == OP_RD) || (cmd_op == OP_WR);

    // NOTE: every variable written in an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        any_open  = 1'b0;
        any_busy  = 1'b0;
        rrd_block = rrd_l_cnt[cmd_bg] != 10'd0;
        ccd_block = ccd_l_cnt[cmd_bg] != 10'd0;
        for (int b = 0; b < NB; b++) begin
            any_open |= (bank_state[b] == B_OPEN);
            any_busy |= (ready_cnt[b] != 10'd0);
        end
        for (int g = 0; g < NG; g++) begin
            if (BG_WIDTH'(g) != cmd_bg) begin
                rrd_block |= (rrd_s_cnt[g] != 10'd0);
                ccd_block |= (ccd_s_cnt[g] != 10'd0);
            end
        end
    end

    // First matching rejection reason wins; 0 means the command is legal.
    always_comb begin
        reject_code = 3'd0;
        if (cmd_valid) begin
            if (cmd_op > OP_REF)                            reject_code = 3'd1;
            else if (g_state == G_REFRESH)                  reject_code = 3'd2;
            else if (cmd_op == OP_REF) begin
                if (any_open)                               reject_code = 3'd3;
                else if (any_busy)                          reject_code = 3'd4;
            end else if (cmd_op == OP_ACT) begin
                if (bank_state[idx] == B_OPEN)              reject_code = 3'd3;
                else if (ready_cnt[idx] != 10'd0)           reject_code = 3'd4;
                else if (rrd_block)                         reject_code = 3'd5;
            end else begin
                if (bank_state[idx] == B_CLOSED)            reject_code = 3'd3;
                else if (ready_cnt[idx] != 10'd0)           reject_code = 3'd4;
                else if (is_rdwr && ccd_block)              reject_code = 3'd6;
            end
        end
    end

    assign accept = cmd_valid && (reject_code == 3'd0);
    assign reject = cmd_valid && (reject_code != 3'd0);

    always_comb begin
        g_next = g_state;
        case (g_state)
            G_RUN:     if (accept && cmd_op == OP_REF && RFC_LOAD != 16'd0) g_next = G_REFRESH;
            G_REFRESH: if (rfc_cnt <= 16'd1) g_next = G_RUN;
            default:   g_next = G_RUN;
        endcase
        for (int b = 0; b < NB; b++) bank_next[b] = bank_state[b];
        if (accept && cmd_op == OP_ACT) bank_next[idx] = B_OPEN;
        if (accept && cmd_op == OP_PRE) bank_next[idx] = B_CLOSED;
    end

    always_comb begin
        new_entry       = '0;
        new_entry.valid = accept && is_rdwr;
        new_entry.is_rd = cmd_op == OP_RD;
        new_entry.bg    = cmd_bg;
        new_entry.bank  = cmd_bank;
        new_entry.col   = cmd_col;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; a later assignment in the same block overrides an earlier one.
    always_ff @(posedge clk) begin
        if (rst) begin
            g_state    <= G_RUN;
            rfc_cnt    <= '0;
            viol       <= 1'b0;
            viol_code  <= 3'd0;
            viol_count <= 16'd0;
            for (int b = 0; b < NB; b++) begin
                bank_state[b] <= B_CLOSED;
                ready_cnt[b]  <= '0;
            end
            for (int g = 0; g < NG; g++) begin
                rrd_l_cnt[g] <= '0;
                rrd_s_cnt[g] <= '0;
                ccd_l_cnt[g] <= '0;
                ccd_s_cnt[g] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            g_state <= g_next;
            rfc_cnt <= (rfc_cnt == 16'd0) ? rfc_cnt : rfc_cnt - 16'd1;
            if (accept && cmd_op == OP_REF) rfc_cnt <= RFC_LOAD;

            for (int b = 0; b < NB; b++) begin
                bank_state[b] <= bank_next[b];
                ready_cnt[b]  <= dec10(ready_cnt[b]);
            end
            if (accept && cmd_op == OP_ACT) ready_cnt[idx] <= RCD_LOAD;
            if (accept && cmd_op == OP_PRE) ready_cnt[idx] <= RP_LOAD;

            for (int g = 0; g < NG; g++) begin
                rrd_l_cnt[g] <= dec10(rrd_l_cnt[g]);
                rrd_s_cnt[g] <= dec10(rrd_s_cnt[g]);
                ccd_l_cnt[g] <= dec10(ccd_l_cnt[g]);
                ccd_s_cnt[g] <= dec10(ccd_s_cnt[g]);
            end
            if (accept && cmd_op == OP_ACT) begin
                rrd_l_cnt[cmd_bg] <= RRDL_LOAD;
                rrd_s_cnt[cmd_bg] <= RRDS_LOAD;
            end
            if (accept && is_rdwr) begin
                ccd_l_cnt[cmd_bg] <= CCDL_LOAD;
                ccd_s_cnt[cmd_bg] <= CCDS_LOAD;
            end

            pipe[0] <= new_entry;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];

            viol <= reject;
            if (reject) begin
                viol_code <= reject_code;
                if (viol_count != 16'hFFFF) viol_count <= viol_count + 16'd1;
            end
        end
    end

    // NOTE: the open-row storage is pure data whose contents are never consulted while a
    // bank is closed, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept && cmd_op == OP_ACT) open_row[idx] <= cmd_row;
    end

    // Burst spacing (T_CCD_S >= T_BURST) guarantees at most one window stage is live.
    always_comb begin
        rd_valid = 1'b0;
        rd_bg    = '0;
        rd_bank  = '0;
        rd_col   = '0;
        rd_beat  = 2'd0;
        wr_req   = 1'b0;
        wr_beat  = 2'd0;
        for (int b = 0; b < T_BURST; b++) begin
            if (pipe[T_CAS-1+b].valid && pipe[T_CAS-1+b].is_rd) begin
                rd_valid = 1'b1;
                rd_bg    = pipe[T_CAS-1+b].bg;
                rd_bank  = pipe[T_CAS-1+b].bank;
                rd_col   = pipe[T_CAS-1+b].col;
                rd_beat  = 2'(b);
            end
            if (pipe[T_CAS-1+b].valid && !pipe[T_CAS-1+b].is_rd) begin
                wr_req  = 1'b1;
                wr_beat = 2'(b);
            end
        end
    end

    always_comb begin
        bank_open = '0;
        for (int b = 0; b < NB; b++) bank_open[b] = (bank_state[b] == B_OPEN);
    end

    assign refreshing = (g_state == G_REFRESH);

endmodule
